// File: rtl/rom_scan_sequencer_pkg.sv
// Shared definitions for the ROM scan sequencer: FSM state codes, scan
// direction codes and a width helper for the step prescaler.
package rom_scan_sequencer_pkg;

  typedef logic [1:0] scanState_t;

  localparam scanState_t ROM_SCAN_IDLE = 2'd0;
  localparam scanState_t ROM_SCAN_RUN  = 2'd1;
  localparam scanState_t ROM_SCAN_WAIT = 2'd2;

  localparam logic ROM_SCAN_DIR_UP   = 1'b0;
  localparam logic ROM_SCAN_DIR_DOWN = 1'b1;

  // Counter width able to hold 0..div-1; never narrower than one bit so a
  // divide-by-one prescaler still has a legal register.
  function automatic int unsigned cntWidth(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/rom_scan_sequencer_prescaler.sv
// Step-rate prescaler for the ROM scan sequencer. Counts enabled cycles up
// to TICK_DIV-1 and flags a tick while parked on the terminal count. The
// count never wraps by itself: the owner clears it when the step is taken,
// so a stalled step keeps the counter parked on its terminal value.
module rom_scan_prescaler
  import rom_scan_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = cntWidth(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             terminal;

  assign terminal = (count_q == LAST_COUNT);
  assign tick_o   = enable_i && terminal;

  // Next count: clear wins, otherwise advance only while enabled and below the terminal count.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !terminal) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rom_scan_sequencer.sv
// ROM scan sequencer: walks the pattern ROM address at a prescaled rate and
// registers each ROM word into a valid/ready output slot. The ROM sits
// beside this block with a combinational read path.
// Optional feature macro: ROM_SCAN_PINGPONG_EN (honours the bounce input so
// the scan reverses at either end instead of wrapping).
module rom_scan_sequencer
  import rom_scan_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              dir_i,
  input  logic              bounce_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  scanState_t        state_q;
  scanState_t        state_d;
  logic              dir_q;
  logic              dir_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] outData_q;
  logic [DATA_W-1:0] outData_d;
  logic              outValid_q;
  logic              outValid_d;

  logic              tick;
  logic              slotFree;
  logic              capture;
  logic              presClear;
  logic              presEnable;
  logic [ADDR_W-1:0] nextAddr;
  logic              nextDir;

  // The prescaler only runs while actively scanning; WAIT and IDLE freeze it.
  assign presEnable = (state_q == ROM_SCAN_RUN);

  rom_scan_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) uPrescaler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (presClear),
    .enable_i (presEnable),
    .tick_o   (tick)
  );

  // A new word can be written when the slot is empty or is being drained this cycle.
  assign slotFree = !outValid_q || out_ready_i;

`ifdef ROM_SCAN_PINGPONG_EN
  // Address/direction after a step: reverse at the ends when bounce is set, wrap otherwise.
  always_comb begin
    nextAddr = addr_q;
    nextDir  = dir_q;
    if (dir_q == ROM_SCAN_DIR_UP) begin
      if (bounce_i && (addr_q == ADDR_MAX)) begin
        nextAddr = ADDR_MAX - ADDR_W'(1);
        nextDir  = ROM_SCAN_DIR_DOWN;
      end else begin
        nextAddr = addr_q + ADDR_W'(1);
      end
    end else begin
      if (bounce_i && (addr_q == '0)) begin
        nextAddr = ADDR_W'(1);
        nextDir  = ROM_SCAN_DIR_UP;
      end else begin
        nextAddr = addr_q - ADDR_W'(1);
      end
    end
  end
`else
  logic unusedBounce;
  assign unusedBounce = bounce_i;

  // Address after a step: plain modular wrap in the latched direction.
  always_comb begin
    nextDir = dir_q;
    if (dir_q == ROM_SCAN_DIR_UP) begin
      nextAddr = addr_q + ADDR_W'(1);
    end else begin
      nextAddr = addr_q - ADDR_W'(1);
    end
  end
`endif

  // Scan FSM: start/stop handling, tick acceptance or stall, and the step itself.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    capture   = 1'b0;
    presClear = 1'b0;
    case (state_q)
      ROM_SCAN_IDLE: begin
        if (start_i && !stop_i) begin
          state_d   = ROM_SCAN_RUN;
          dir_d     = dir_i;
          addr_d    = (dir_i == ROM_SCAN_DIR_DOWN) ? ADDR_MAX : '0;
          presClear = 1'b1;
        end
      end
      ROM_SCAN_RUN: begin
        if (stop_i) begin
          state_d = ROM_SCAN_IDLE;
        end else if (tick) begin
          if (slotFree) begin
            capture = 1'b1;
          end else begin
            state_d = ROM_SCAN_WAIT;
          end
        end
      end
      ROM_SCAN_WAIT: begin
        if (stop_i) begin
          state_d = ROM_SCAN_IDLE;
        end else if (out_ready_i) begin
          capture = 1'b1;
          state_d = ROM_SCAN_RUN;
        end
      end
      default: begin
        state_d = ROM_SCAN_IDLE;
      end
    endcase
    if (capture) begin
      addr_d    = nextAddr;
      dir_d     = nextDir;
      presClear = 1'b1;
    end
  end

  // Output slot: a capture loads a fresh word, otherwise a consumed word empties the slot.
  always_comb begin
    outData_d  = outData_q;
    outValid_d = outValid_q;
    if (capture) begin
      outData_d  = rom_data_i;
      outValid_d = 1'b1;
    end else if (outValid_q && out_ready_i) begin
      outValid_d = 1'b0;
    end
  end

  // State, direction, address and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ROM_SCAN_IDLE;
      dir_q      <= ROM_SCAN_DIR_UP;
      addr_q     <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

  assign rom_addr_o  = addr_q;
  assign out_data_o  = outData_q;
  assign out_valid_o = outValid_q;
  assign busy_o      = (state_q != ROM_SCAN_IDLE);

endmodule

// File: tb/tb_rom_scan_sequencer.sv
// Self-checking bench for rom_scan_sequencer with TICK_DIV=4 and a one-hot
// pattern ROM attached. A behavioural model tracks the expected outputs
// every cycle; directed scenarios pin the model with literal values, then a
// randomized phase exercises start/stop/reset/backpressure mixes.
module tb_rom_scan_sequencer;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;
  localparam int TICK_DIV = 4;
  localparam int NADDR    = 1 << ADDR_W;

`ifdef ROM_SCAN_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic              stop;
  logic              dir;
  logic              bounce;
  logic [ADDR_W-1:0] romAddr;
  logic [DATA_W-1:0] romData;
  logic [DATA_W-1:0] outData;
  logic              outValid;
  logic              outReady;
  logic              busy;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: mode 0 idle, 1 scanning, 2 stalled on a full slot.
  int  mMode  = 0;
  int  mAddr  = 0;
  int  mDir   = 0;
  int  mLeft  = 0;
  int  mData  = 0;
  bit  mValid = 0;
  bit  armed  = 0;

  // One-hot pattern ROM with a combinational read path.
  assign romData = 8'h01 << romAddr;

  rom_scan_sequencer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .dir_i       (dir),
    .bounce_i    (bounce),
    .rom_addr_o  (romAddr),
    .rom_data_i  (romData),
    .out_data_o  (outData),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit p, input bit d,
                               input bit b, input bit rdy);
    rst      = r;
    start    = s;
    stop     = p;
    dir      = d;
    bounce   = b;
    outReady = rdy;
  endtask

  // Next scan position from the scan rules: wrap, or reverse at an end when bouncing.
  task automatic modelAdvance();
    if (PINGPONG && bounce && mDir == 0 && mAddr == NADDR - 1) begin
      mDir  = 1;
      mAddr = NADDR - 2;
    end else if (PINGPONG && bounce && mDir == 1 && mAddr == 0) begin
      mDir  = 0;
      mAddr = 1;
    end else if (mDir == 0) begin
      mAddr = (mAddr + 1) % NADDR;
    end else begin
      mAddr = (mAddr + NADDR - 1) % NADDR;
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs sampled on that edge.
  task automatic modelStep();
    bit cap;
    bit oldValid;
    if (rst) begin
      mMode = 0; mAddr = 0; mDir = 0; mLeft = 0; mData = 0; mValid = 0;
      armed = 1;
      return;
    end
    cap      = 0;
    oldValid = mValid;
    if (mMode == 0) begin
      if (start && !stop) begin
        mMode = 1;
        mDir  = dir;
        mAddr = dir ? NADDR - 1 : 0;
        mLeft = TICK_DIV - 1;
      end
    end else if (stop) begin
      mMode = 0;
    end else if (mMode == 1) begin
      if (mLeft == 0) begin
        if (!oldValid || outReady) cap = 1;
        else mMode = 2;
      end else begin
        mLeft--;
      end
    end else begin
      if (outReady) begin
        cap   = 1;
        mMode = 1;
      end
    end
    if (cap) begin
      mData  = 1 << mAddr;
      mValid = 1;
      modelAdvance();
      mLeft  = TICK_DIV - 1;
    end else if (oldValid && outReady) begin
      mValid = 0;
    end
  endtask

  // Compare process: advance the model on each rising edge, check DUT on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      if (armed) begin
        checkOutput("model.rom_addr", int'(romAddr), mAddr);
        checkOutput("model.out_data", int'(outData), mData);
        checkOutput("model.out_valid", int'(outValid), int'(mValid));
        checkOutput("model.busy", int'(busy), (mMode != 0) ? 1 : 0);
      end
    end
  end

  task automatic pulseStart(input bit d, input bit b);
    applyStimulus(0, 1, 0, d, b, outReady);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    logic [7:0] expUp[9];
    logic [7:0] expDown[9];
    logic [7:0] expBounce[10];
    bit found;

    expUp     = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    expDown   = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    if (PINGPONG)
      expBounce = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
    else
      expBounce = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

    applyStimulus(1, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    checkOutput("reset.rom_addr", int'(romAddr), 0);
    checkOutput("reset.out_valid", int'(outValid), 0);
    checkOutput("reset.busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Scan up with a consumer that is always ready.
    pulseStart(0, 0);
    checkOutput("up.busy", int'(busy), 1);
    checkOutput("up.start_addr", int'(romAddr), 0);
    for (int k = 0; k < 9; k++) begin
      repeat (TICK_DIV) @(negedge clk);
      checkOutput("up.data", int'(outData), int'(expUp[k]));
      checkOutput("up.valid", int'(outValid), 1);
    end
    pulseStop();
    checkOutput("up.stop_busy", int'(busy), 0);

    // Scan down.
    pulseStart(1, 0);
    checkOutput("down.start_addr", int'(romAddr), 7);
    for (int k = 0; k < 9; k++) begin
      repeat (TICK_DIV) @(negedge clk);
      checkOutput("down.data", int'(outData), int'(expDown[k]));
    end
    pulseStop();

    // Backpressure after the first beat stalls the scan.
    pulseStart(0, 0);
    repeat (TICK_DIV) @(negedge clk);
    checkOutput("stall.first", int'(outData), 8'h01);
    outReady = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("stall.valid", int'(outValid), 1);
    checkOutput("stall.data", int'(outData), 8'h01);
    checkOutput("stall.addr", int'(romAddr), 1);
    checkOutput("stall.busy", int'(busy), 1);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("stall.release_data", int'(outData), 8'h02);
    checkOutput("stall.release_addr", int'(romAddr), 2);

    // Stop at address 5.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (romAddr == 3'd5) found = 1;
      else @(negedge clk);
    end
    checkOutput("stop.reached_addr5", int'(found), 1);
    pulseStop();
    checkOutput("stop.busy", int'(busy), 0);
    checkOutput("stop.addr", int'(romAddr), 5);
    repeat (8) @(negedge clk);
    checkOutput("stop.no_new_valid", int'(outValid), 0);
    checkOutput("stop.addr_hold", int'(romAddr), 5);
    applyStimulus(0, 1, 1, 0, 0, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("start_stop.busy", int'(busy), 0);
    checkOutput("start_stop.addr", int'(romAddr), 5);

    // Bounce request: reverses at the end only when the feature is built in.
    pulseStart(0, 1);
    for (int k = 0; k < 10; k++) begin
      repeat (TICK_DIV) @(negedge clk);
      checkOutput("bounce.data", int'(outData), int'(expBounce[k]));
    end
    pulseStop();
    bounce = 1'b0;

    // Reset while stalled, then a fresh start from address 0.
    pulseStart(0, 0);
    repeat (TICK_DIV) @(negedge clk);
    outReady = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_wait.busy", int'(busy), 0);
    checkOutput("rst_wait.valid", int'(outValid), 0);
    checkOutput("rst_wait.data", int'(outData), 0);
    checkOutput("rst_wait.addr", int'(romAddr), 0);
    outReady = 1'b1;
    pulseStart(0, 0);
    checkOutput("restart.addr", int'(romAddr), 0);
    repeat (TICK_DIV) @(negedge clk);
    checkOutput("restart.data", int'(outData), 8'h01);

    // Randomized mix of control, direction, bounce and backpressure.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
